gray_seq_monitor: RTL and testbench

//  Downstream consumer of the 4-bit synchronous Gray counter (SR-flop based, updates on falling clk).

---
 rtl/gray_pkg.sv | 27 ++
 rtl/gray_to_bin.sv | 20 ++
 rtl/gray_seq_monitor.sv | 148 ++++++++++++++
 tb/tb_gray_seq_monitor.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-sequence monitor.
// Contents:
//   state_t  - monitor FSM state (ACQUIRE / LOCKED / FAULT)
//   GRAY_W   - native width of the upstream Gray counter
//   GRAY_MAX - Gray code of the counter's maximum count (binary 2^GRAY_W-1)
//   g2b()    - Gray-to-binary conversion at GRAY_W bits
package gray_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKED  = 2'd1,
    FAULT   = 2'd2
  } state_t;

  localparam int unsigned GRAY_W = 4;
  localparam logic [GRAY_W-1:0] GRAY_MAX = 4'b1000;

  function automatic logic [GRAY_W-1:0] g2b(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int unsigned i = 0; i < GRAY_W - 1; i++) begin
      b[GRAY_W-2-i] = b[GRAY_W-1-i] ^ g[GRAY_W-2-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter.
// Ports:
//   g_i [WIDTH-1:0]  Gray code in
//   b_o [WIDTH-1:0]  binary equivalent (b[W-1]=g[W-1]; b[i]=b[i+1]^g[i])
module gray_to_bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] b_o
);

  always_comb begin
    b_o = '0;
    b_o[WIDTH-1] = g_i[WIDTH-1];
    for (int unsigned i = 0; i < WIDTH - 1; i++) begin
      b_o[WIDTH-2-i] = b_o[WIDTH-1-i] ^ g_i[WIDTH-2-i];
    end
  end

endmodule

// File: rtl/gray_seq_monitor.sv
// Gray sequence monitor: samples an upstream Gray counter on posedge,
// registers its binary value and checks that every change is a single
// forward Gray step. Tracks lock, wrap and fault status.
// Ports:
//   clk        system clock, all flops on posedge
//   preset     asynchronous active-low reset
//   gray_in    Gray code from upstream counter
//   valid_in   gray_in meaningful this cycle
//   bin_out    registered binary of last sample
//   bin_valid  bin_out holds at least one sample
//   locked     FSM is in LOCKED
//   step_err   1-cycle pulse on an illegal step while LOCKED
//   wrap       1-cycle pulse on a legal max->0 step while LOCKED
//   err_count  saturating count of step_err pulses
module gray_seq_monitor
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             preset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             step_err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
  localparam logic [WIDTH:0]   LOCK_C  = (WIDTH+1)'(LOCK_CNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             bin_valid_q, bin_valid_d;
  logic [WIDTH-1:0] good_cnt_q, good_cnt_d;
  logic             step_err_q, step_err_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [WIDTH-1:0] bin_new, bin_prev, diff;
  logic [WIDTH:0]   good_inc;
  logic             is_hold, is_good;

  gray_to_bin #(.WIDTH(WIDTH)) u_g2b_in   (.g_i(gray_in), .b_o(bin_new));
  gray_to_bin #(.WIDTH(WIDTH)) u_g2b_prev (.g_i(prev_q),  .b_o(bin_prev));

  // Exactly-one-bit-set test on the full-width difference stands in for popcount==1.
  always_comb begin
    diff     = gray_in ^ prev_q;
    is_hold  = (diff == '0);
    is_good  = !is_hold && ((diff & (diff - ONE)) == '0) &&
               (bin_new == bin_prev + ONE);
    good_inc = {1'b0, good_cnt_q} + {{WIDTH{1'b0}}, 1'b1};
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    bin_d       = bin_q;
    bin_valid_d = bin_valid_q;
    good_cnt_d  = good_cnt_q;
    step_err_d  = 1'b0;
    wrap_d      = 1'b0;
    err_d       = err_q;

    if (valid_in) begin
      prev_d      = gray_in;
      bin_d       = bin_new;
      bin_valid_d = 1'b1;
      have_prev_d = 1'b1;

      if (have_prev_q && !is_hold) begin
        unique case (state_q)
          ACQUIRE: begin
            if (is_good) begin
              if (good_inc >= LOCK_C) begin
                state_d    = LOCKED;
                good_cnt_d = '0;
              end else begin
                good_cnt_d = good_cnt_q + ONE;
              end
            end else begin
              good_cnt_d = '0;
            end
          end
          LOCKED: begin
            if (is_good) begin
              wrap_d = (bin_prev == '1);
            end else begin
              state_d    = FAULT;
              step_err_d = 1'b1;
              if (err_q != '1) err_d = err_q + ERR_ONE;
            end
          end
          FAULT: begin
            state_d    = ACQUIRE;
            good_cnt_d = is_good ? ONE : '0;
          end
          default: begin
            state_d    = ACQUIRE;
            good_cnt_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      state_q     <= ACQUIRE;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      good_cnt_q  <= '0;
      step_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      good_cnt_q  <= good_cnt_d;
      step_err_q  <= step_err_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = bin_valid_q;
  assign locked    = (state_q == LOCKED);
  assign step_err  = step_err_q;
  assign wrap      = wrap_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Bench for gray_seq_monitor: a default instance plus an ERR_W=2 instance
// on the same inputs, checked against a behavioural model.
module tb_gray_seq_monitor;

  logic       clk = 1'b0;
  logic       preset = 1'b0;
  logic [3:0] gray_in = '0;
  logic       valid_in = 1'b0;

  logic [3:0] bin_out, bin_out2;
  logic       bin_valid, locked, step_err, wrap;
  logic       bin_valid2, locked2, step_err2, wrap2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  gray_seq_monitor #(.WIDTH(4), .ERR_W(8), .LOCK_CNT(2)) dut (
    .clk(clk), .preset(preset), .gray_in(gray_in), .valid_in(valid_in),
    .bin_out(bin_out), .bin_valid(bin_valid), .locked(locked),
    .step_err(step_err), .wrap(wrap), .err_count(err_count)
  );

  gray_seq_monitor #(.WIDTH(4), .ERR_W(2), .LOCK_CNT(2)) dut_sat (
    .clk(clk), .preset(preset), .gray_in(gray_in), .valid_in(valid_in),
    .bin_out(bin_out2), .bin_valid(bin_valid2), .locked(locked2),
    .step_err(step_err2), .wrap(wrap2), .err_count(err_count2)
  );

  logic [21:0] act_v;
  assign act_v = {bin_out, bin_valid, locked, step_err, wrap, err_count,
                  err_count2, bin_valid2 ^ bin_valid, locked2 ^ locked,
                  step_err2 ^ step_err, wrap2 ^ wrap};

  // ---------------- behavioural reference model ----------------
  int unsigned m_bin, m_prevg, m_prevbin, m_goods, m_errs;
  bit          m_have, m_bvalid, m_step, m_wrap;
  string       m_mode;

  function automatic int unsigned to_bin(input int unsigned g);
    int unsigned b = 0;
    for (int unsigned s = g; s != 0; s = s >> 1) b = b ^ s;
    return b & 15;
  endfunction

  function automatic int unsigned to_gray(input int unsigned b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic void model_reset();
    m_bin = 0; m_prevg = 0; m_prevbin = 0; m_goods = 0; m_errs = 0;
    m_have = 0; m_bvalid = 0; m_step = 0; m_wrap = 0; m_mode = "ACQ";
  endfunction

  function automatic void model_step(input int unsigned g, input bit v);
    int unsigned nb;
    bit hold, good;
    m_step = 0;
    m_wrap = 0;
    if (!v) return;
    nb = to_bin(g);
    if (m_have) begin
      hold = (g == m_prevg);
      good = ($countones(g ^ m_prevg) == 1) && (nb == ((m_prevbin + 1) % 16));
      if (!hold) begin
        if (m_mode == "ACQ") begin
          if (good) begin
            m_goods++;
            if (m_goods >= 2) begin m_mode = "LOCK"; m_goods = 0; end
          end else m_goods = 0;
        end else if (m_mode == "LOCK") begin
          if (good) m_wrap = (m_prevbin == 15);
          else begin m_mode = "FAULT"; m_step = 1; m_errs++; end
        end else begin
          m_mode = "ACQ";
          m_goods = good ? 1 : 0;
        end
      end
    end
    m_have = 1; m_bvalid = 1; m_prevg = g; m_prevbin = nb; m_bin = nb;
  endfunction

  function automatic logic [21:0] exp_vec();
    logic [7:0] e8;
    logic [1:0] e2;
    e8 = (m_errs > 255) ? 8'hFF : 8'(m_errs);
    e2 = (m_errs > 3) ? 2'd3 : 2'(m_errs);
    return {4'(m_bin), m_bvalid, (m_mode == "LOCK"), m_step, m_wrap, e8, e2, 4'b0000};
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic cycle(input logic [3:0] g, input logic v);
    gray_in = g;
    valid_in = v;
    @(posedge clk);
    #1;
    model_step(32'(g), v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    preset = 1'b0;
    valid_in = 1'b0;
    model_reset();
    @(negedge clk);
    preset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    preset = 1'b0;
    gray_in = 4'b0110;
    valid_in = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (act_v !== 22'h0) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want %h", act_v, 22'h0);
    end
    @(negedge clk);
    preset = 1'b1;
    cycle(4'b0110, 1'b1);
    n_cmp++;
    if (bin_out !== 4'd4 || bin_valid !== 1'b1 || act_v !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_first_sample: got %h want %h", act_v, exp_vec());
    end
  endtask

  task automatic test_lock_acquire();
    logic [3:0] seq [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(seq[i], 1'b1);
      n_cmp++;
      if (bin_out !== 4'(i) || locked !== (i >= 2) || act_v !== exp_vec()) begin
        n_bad++;
        $display("FAIL lock_acquire[%0d]: got %h want %h", i, act_v, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    int wraps = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(4'(to_gray(32'(i % 16))), 1'b1);
      if (wrap) wraps++;
      n_cmp++;
      if (act_v !== exp_vec() || step_err !== 1'b0 || wrap !== (i == 16)) begin
        n_bad++;
        $display("FAIL wrap_run[%0d]: got %h want %h", i, act_v, exp_vec());
      end
    end
    n_cmp++;
    if (wraps != 1) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d want 1", wraps);
    end
  endtask

  task automatic test_fault();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(4'(to_gray(32'(i))), 1'b1);
    n_cmp++;
    if (locked !== 1'b1 || bin_out !== 4'd4) begin
      n_bad++;
      $display("FAIL fault_setup: got locked=%b bin=%0d want locked=1 bin=4", locked, bin_out);
    end
    cycle(4'b0101, 1'b1);
    n_cmp++;
    if (step_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || act_v !== exp_vec()) begin
      n_bad++;
      $display("FAIL fault_inject: got %h want %h", act_v, exp_vec());
    end
    cycle(4'b0111, 1'b1);
    n_cmp++;
    if (step_err !== 1'b0 || locked !== 1'b0 || act_v !== exp_vec() || m_mode != "ACQ") begin
      n_bad++;
      $display("FAIL fault_exit: got %h want %h", act_v, exp_vec());
    end
    cycle(4'b0111, 1'b0);
    n_cmp++;
    if (act_v !== exp_vec()) begin
      n_bad++;
      $display("FAIL valid_low: got %h want %h", act_v, exp_vec());
    end
  endtask

  task automatic test_hold_backward();
    do_reset();
    cycle(4'b0000, 1'b1);
    cycle(4'b0001, 1'b1);
    cycle(4'b0011, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0011, 1'b1);
      n_cmp++;
      if (locked !== 1'b1 || step_err !== 1'b0 || wrap !== 1'b0 || act_v !== exp_vec()) begin
        n_bad++;
        $display("FAIL hold[%0d]: got %h want %h", i, act_v, exp_vec());
      end
    end
    cycle(4'b0001, 1'b1);
    n_cmp++;
    if (step_err !== 1'b1 || act_v !== exp_vec()) begin
      n_bad++;
      $display("FAIL backward_step: got %h want %h", act_v, exp_vec());
    end
  endtask

  // Relock/err loop: LOCK then one bad step, repeated n times, ending locked.
  task automatic build_errors(input int n);
    do_reset();
    cycle(4'b0000, 1'b1);
    cycle(4'b0001, 1'b1);
    cycle(4'b0011, 1'b1);
    for (int i = 0; i < n; i++) begin
      cycle(4'b0000, 1'b1);
      cycle(4'b0001, 1'b1);
      cycle(4'b0011, 1'b1);
      cycle(4'b0010, 1'b1);
    end
  endtask

  task automatic test_async_reset();
    build_errors(3);
    n_cmp++;
    if (locked !== 1'b1 || err_count !== 8'd3 || act_v !== exp_vec()) begin
      n_bad++;
      $display("FAIL async_setup: got %h want %h", act_v, exp_vec());
    end
    preset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (act_v !== 22'h0) begin
      n_bad++;
      $display("FAIL async_clear: got %h want %h", act_v, 22'h0);
    end
    @(negedge clk);
    preset = 1'b1;
  endtask

  task automatic test_err_saturate();
    build_errors(5);
    n_cmp++;
    if (err_count2 !== 2'd3 || err_count !== 8'd5 || act_v !== exp_vec()) begin
      n_bad++;
      $display("FAIL err_saturate: got err=%0d err2=%0d want err=5 err2=3", err_count, err_count2);
    end
  endtask

  // Upstream counter modelled live: updates on falling edge, occasional stall.
  task automatic test_live_counter();
    int unsigned cnt = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gray_in = 4'(to_gray(cnt));
      valid_in = 1'b1;
      if ($urandom_range(0, 5) != 0) cnt = (cnt + 1) % 16;
      @(posedge clk);
      #1;
      model_step(32'(gray_in), 1'b1);
      n_cmp++;
      if (act_v !== exp_vec()) begin
        n_bad++;
        $display("FAIL live[%0d]: got %h want %h", i, act_v, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int unsigned r;
    logic [3:0] g;
    logic v;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      v = 1'b1;
      if (r < 60)      g = 4'(to_gray((m_prevbin + 1) % 16));
      else if (r < 72) g = 4'(m_prevg);
      else if (r < 82) begin g = 4'($urandom_range(0, 15)); v = 1'b0; end
      else             g = 4'($urandom_range(0, 15));
      cycle(g, v);
      n_cmp++;
      if (act_v !== exp_vec() || (wrap && step_err)) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h want %h", i, act_v, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_wrap();
    test_fault();
    test_hold_backward();
    test_async_reset();
    test_err_saturate();
    test_live_counter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
